// File: rtl/graph_pkg.sv
// Shared definitions for the graph-solver input bus: field widths, the packed
// edge entry layout and the packer FSM states.
package graph_pkg;

  localparam int unsigned EDGE_W    = 12;
  localparam int unsigned NODE_W    = 4;
  localparam int unsigned MAX_EDGES = 255;
  localparam int unsigned DATA_W    = 3072;

  // Bit offsets of each field inside a packed 12-bit entry
  localparam int unsigned PARENT_LSB = 0;
  localparam int unsigned CHILD_LSB  = 4;
  localparam int unsigned WEIGHT_LSB = 8;

  // Packed entry; declaration order puts weight in the MSBs, parent in the LSBs
  typedef struct packed {
    logic [NODE_W-1:0] weight;
    logic [NODE_W-1:0] child;
    logic [NODE_W-1:0] parent;
  } edge_t;

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Larger of two node ids
  function automatic logic [NODE_W-1:0] node_max(input logic [NODE_W-1:0] a,
                                                 input logic [NODE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_validate.sv
// Combinational edge check: an edge is storable when both endpoints are
// non-zero and distinct. Also supplies the larger endpoint for node counting.
module edge_validate
  import graph_pkg::*;
(
  input  logic [3:0] parent,
  input  logic [3:0] child,
  output logic       edge_ok,
  output logic [3:0] max_id
);

  // Validity and larger endpoint
  always_comb begin
    edge_ok = (parent != '0) && (child != '0) && (parent != child);
    max_id  = node_max(parent, child);
  end

endmodule

// File: rtl/edge_list_packer.sv
// Transmitter side of the graph-solver input bus. Collects edges from a
// valid/ready stream into a packed frame and holds it until the solver takes it.
module edge_list_packer
  import graph_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_parent,
  input  logic [3:0]    in_child,
  input  logic [3:0]    in_weight,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_n,
  output logic [7:0]    out_e,
  output logic [3071:0] out_data,
  output logic          err_drop
);

  state_t               state_q, state_d;
  logic [7:0]           e_q, e_d;
  logic [3:0]           n_q, n_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 drop_q, drop_d;

  logic                 edge_ok;
  logic [3:0]           edge_max;
  logic [11:0]          wr_base;
  edge_t                wr_entry;

  edge_validate u_validate (
    .parent  (in_parent),
    .child   (in_child),
    .edge_ok (edge_ok),
    .max_id  (edge_max)
  );

  // Handshake outputs depend on state only
  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == PRESENT);
    out_n     = n_q;
    out_e     = e_q;
    out_data  = data_q;
    err_drop  = drop_q;
  end

  // Next-state and frame update
  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    n_d      = n_q;
    data_d   = data_q;
    drop_d   = 1'b0;
    wr_base  = 12'(e_q) * 12'(EDGE_W);
    wr_entry = '{weight: in_weight, child: in_child, parent: in_parent};

    case (state_q)
      FILL: begin
        if (in_valid) begin
          if (edge_ok) begin
            data_d[wr_base +: EDGE_W] = wr_entry;
            e_d = e_q + 8'd1;
            n_d = node_max(n_q, edge_max);
            // Forced close once the frame is full, regardless of in_last
            if (in_last || (e_q == 8'(MAX_EDGES - 1))) begin
              state_d = PRESENT;
            end
          end else begin
            drop_d = 1'b1;
            if (in_last) begin
              state_d = PRESENT;
            end
          end
        end
      end
      PRESENT: begin
        // Clearing on acceptance keeps entries beyond out_e at zero
        if (out_ready) begin
          state_d = FILL;
          e_d     = '0;
          n_d     = '0;
          data_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and frame registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      e_q     <= '0;
      n_q     <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      n_q     <= n_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_edge_list_packer.sv
// Directed testbench for edge_list_packer with hand-computed expectations.
module tb_edge_list_packer;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_parent;
  logic [3:0]    in_child;
  logic [3:0]    in_weight;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_n;
  logic [7:0]    out_e;
  logic [3071:0] out_data;
  logic          err_drop;

  int tests = 0;
  int fails = 0;

  edge_list_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_parent (in_parent),
    .in_child  (in_child),
    .in_weight (in_weight),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n),
    .out_e     (out_e),
    .out_data  (out_data),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one edge, wait (bounded) for in_ready, transfer on the next edge
  task automatic send(input logic [3:0] p, input logic [3:0] c,
                      input logic [3:0] w, input logic last);
    int unsigned cnt;
    in_valid  = 1'b1;
    in_parent = p;
    in_child  = c;
    in_weight = w;
    in_last   = last;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    if (cnt >= 100) check("send_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [3071:0] snap;
  logic          stable;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_parent = '0; in_child = '0;
    in_weight = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_e", 64'(out_e), 64'd0);
    check("rst_out_n", 64'(out_n), 64'd0);
    check("rst_data_zero", 64'(out_data == '0), 64'd1);
    check("rst_err_drop", 64'(err_drop), 64'd0);

    // Test 1: two-edge frame
    send(4'd1, 4'd2, 4'd5, 1'b0);
    check("t1_no_valid_yet", 64'(out_valid), 64'd0);
    send(4'd2, 4'd3, 4'd7, 1'b1);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_in_ready", 64'(in_ready), 64'd0);
    check("t1_out_e", 64'(out_e), 64'd2);
    check("t1_out_n", 64'(out_n), 64'd3);
    check("t1_entry0", 64'(out_data[11:0]), 64'h521);
    check("t1_entry1", 64'(out_data[23:12]), 64'h732);
    check("t1_rest_zero", 64'(out_data[3071:24] == '0), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_acc_in_ready", 64'(in_ready), 64'd1);
    check("t1_acc_out_valid", 64'(out_valid), 64'd0);
    check("t1_acc_data_zero", 64'(out_data == '0), 64'd1);

    // Test 2: only dropped edges
    send(4'd0, 4'd4, 4'd1, 1'b0);
    check("t2_drop1", 64'(err_drop), 64'd1);
    check("t2_e_after_drop", 64'(out_e), 64'd0);
    send(4'd3, 4'd3, 4'd2, 1'b1);
    check("t2_drop2", 64'(err_drop), 64'd1);
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_out_e", 64'(out_e), 64'd0);
    check("t2_out_n", 64'(out_n), 64'd0);
    check("t2_data_zero", 64'(out_data == '0), 64'd1);
    tick();
    check("t2_drop_one_cycle", 64'(err_drop), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Test 3: forced close at 255 edges
    for (int k = 0; k < 255; k++) begin
      send(4'(k % 15 + 1), 4'((k + 1) % 15 + 1), 4'(k % 16), 1'b0);
    end
    check("t3_out_valid", 64'(out_valid), 64'd1);
    check("t3_out_e", 64'(out_e), 64'd255);
    check("t3_out_n", 64'(out_n), 64'd15);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_entry0", 64'(out_data[11:0]), 64'h021);
    check("t3_entry13", 64'(out_data[13*12 +: 12]), 64'hDFE);
    check("t3_entry254", 64'(out_data[254*12 +: 12]), 64'hE1F);
    check("t3_tail_zero", 64'(out_data[3071:3060] == '0), 64'd1);

    // Test 4: hold in PRESENT with upstream pushing
    snap = out_data;
    stable = 1'b1;
    in_valid = 1'b1; in_parent = 4'd1; in_child = 4'd2; in_weight = 4'd3; in_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_data !== snap || out_e !== 8'd255 || out_n !== 4'd15 ||
          out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("t4_stable", 64'(stable), 64'd1);
    check("t4_out_e", 64'(out_e), 64'd255);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_in_ready", 64'(in_ready), 64'd1);
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_out_e", 64'(out_e), 64'd0);
    check("t4_data_zero", 64'(out_data == '0), 64'd1);

    // Test 5: reset mid-frame
    send(4'd1, 4'd2, 4'd1, 1'b0);
    send(4'd2, 4'd3, 4'd2, 1'b0);
    send(4'd3, 4'd4, 4'd3, 1'b0);
    check("t5_e_before_rst", 64'(out_e), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_out_e", 64'(out_e), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_data_zero", 64'(out_data == '0), 64'd1);
    send(4'd5, 4'd9, 4'hF, 1'b1);
    check("t5_out_valid", 64'(out_valid), 64'd1);
    check("t5_out_e1", 64'(out_e), 64'd1);
    check("t5_out_n", 64'(out_n), 64'd9);
    check("t5_entry0", 64'(out_data[11:0]), 64'hF95);
    check("t5_rest_zero", 64'(out_data[3071:12] == '0), 64'd1);

    // Test 6: back-to-back frames with out_ready tied high
    out_ready = 1'b1;
    tick();
    check("t6_accept", 64'(in_ready), 64'd1);
    send(4'd7, 4'd8, 4'd1, 1'b0);
    send(4'd8, 4'd9, 4'd2, 1'b0);
    send(4'd9, 4'd10, 4'd3, 1'b1);
    check("t6a_out_valid", 64'(out_valid), 64'd1);
    check("t6a_out_e", 64'(out_e), 64'd3);
    check("t6a_out_n", 64'(out_n), 64'd10);
    check("t6a_entry2", 64'(out_data[35:24]), 64'h3A9);
    send(4'd1, 4'd3, 4'd4, 1'b1);
    check("t6b_out_valid", 64'(out_valid), 64'd1);
    check("t6b_out_e", 64'(out_e), 64'd1);
    check("t6b_out_n", 64'(out_n), 64'd3);
    check("t6b_entry0", 64'(out_data[11:0]), 64'h431);
    check("t6b_no_residue", 64'(out_data[3071:12] == '0), 64'd1);
    tick();
    check("t6b_consumed", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
